// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_gen
// Brief    : NUM_CH independent programmable clock dividers with freeze,
//            glitch-free half-period reload and single-cycle edge ticks.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 16,
    parameter int RESET_HALF = 20
) (
    input  logic                    clk1,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] half_per,
    input  logic [NUM_CH-1:0]       load,
    output logic [NUM_CH-1:0]       load_ack,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_tick,
    output logic [NUM_CH-1:0]       fall_tick
);

    localparam logic [CNT_W-1:0] c_reset_half = CNT_W'(RESET_HALF);
    localparam logic [CNT_W-1:0] c_one        = CNT_W'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] r_active_half;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] r_pend_half;
        logic             r_pend_vld;
        logic             r_clk;
        logic             r_rise;
        logic             r_fall;
        logic             r_ack;
        logic [CNT_W-1:0] w_req;
        logic [CNT_W-1:0] w_last;
        logic             w_wrap;

        assign w_req  = half_per[i*CNT_W +: CNT_W];
        // A programmed half-period of 0 behaves as 1, so the terminal count is 0.
        assign w_last = (r_active_half == '0) ? '0 : (r_active_half - c_one);
        assign w_wrap = (r_cnt == w_last);

        always_ff @(posedge clk1) begin
            if (rst) begin
                r_active_half <= c_reset_half;
                r_cnt         <= '0;
                r_pend_half   <= '0;
                r_pend_vld    <= 1'b0;
                r_clk         <= 1'b0;
                r_rise        <= 1'b0;
                r_fall        <= 1'b0;
                r_ack         <= 1'b0;
            end else begin
                r_rise <= 1'b0;
                r_fall <= 1'b0;
                r_ack  <= 1'b0;
                if (en[i]) begin
                    if (w_wrap) begin
                        r_cnt  <= '0;
                        r_clk  <= ~r_clk;
                        r_rise <= ~r_clk;
                        r_fall <= r_clk;
                        // New half-period only takes effect at a phase boundary.
                        if (r_pend_vld) begin
                            r_active_half <= r_pend_half;
                            r_pend_vld    <= 1'b0;
                            r_ack         <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_one;
                    end
                    // Placed after the apply so a load on a toggle edge stays pending.
                    if (load[i]) begin
                        r_pend_half <= w_req;
                        r_pend_vld  <= 1'b1;
                    end
                end else if (load[i]) begin
                    r_active_half <= w_req;
                    r_cnt         <= '0;
                    r_pend_vld    <= 1'b0;
                    r_ack         <= 1'b1;
                end
            end
        end

        assign clk_out[i]   = r_clk;
        assign rise_tick[i] = r_rise;
        assign fall_tick[i] = r_fall;
        assign load_ack[i]  = r_ack;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_gen.md
Name: clk_div_gen

Overview:
- Synthesizable, multi-channel successor to the free-running simulation clock toggler.
- Produces NUM_CH independent divided clocks from clk1, each with a programmable half-period in clk1 cycles.
- Each channel supports enable/freeze, a glitch-free divisor reload handshake, and single-cycle edge ticks.
- Sits at the top of the design, feeding slow clocks and clock-enables to downstream blocks and benches.

Parameters:
- NUM_CH, 4, number of independent output channels.
- CNT_W, 16, width of the half-period value and the internal counter.
- RESET_HALF, 20, half-period each channel uses out of reset.

Ports:
- clk1  in  1  single system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- half_per  in  NUM_CH*CNT_W  requested half-period; channel i uses bits [i*CNT_W +: CNT_W].
- load  in  NUM_CH  per-channel request to capture half_per[i].
- load_ack  out  NUM_CH  one-cycle pulse when the new half-period becomes active.
- clk_out  out  NUM_CH  divided clock level.
- rise_tick  out  NUM_CH  one-cycle pulse in the first cycle clk_out[i] is 1.
- fall_tick  out  NUM_CH  one-cycle pulse in the first cycle clk_out[i] is 0.

Behaviour:
- Reset (rst=1 sampled on a clk1 edge), every channel:
  - clk_out=0, rise_tick=0, fall_tick=0, load_ack=0.
  - cnt=0, active_half=RESET_HALF, pending flag cleared.
  - rst overrides en and load in the same cycle.
- Per-channel state: active_half (CNT_W), cnt (CNT_W), pend_half (CNT_W), pend_vld (1).
- Effective half-period H = max(active_half, 1); a programmed value of 0 behaves as 1.
- Counting when en[i]=1:
  - if cnt==H-1: cnt<=0, clk_out toggles, and exactly one of rise_tick/fall_tick is set for the next cycle.
  - otherwise: cnt<=cnt+1.
  - Resulting period is 2*H clk1 cycles at 50% duty. First rise occurs H enabled edges after reset.
- All outputs are registered; ticks are 0 in every cycle without a toggle.
- Freeze (en[i]=0):
  - cnt and clk_out hold their values; no ticks.
  - Reasserting en resumes from the held cnt, with no phase restart.
- Reload while enabled:
  - load[i]=1 captures half_per[i] into pend_half and sets pend_vld.
  - On the next toggle event: active_half<=pend_half, pend_vld cleared, load_ack pulses in the same cycle the toggled clk_out level appears.
  - The phase in progress always completes with the old H, so there are no runt pulses.
  - Load in the same cycle as a toggle event: captured into pending, applied at the following toggle.
  - Repeated loads before application: last value wins, single load_ack.
- Reload while disabled:
  - load[i]=1 with en[i]=0 applies directly: active_half<=half_per[i] and cnt<=0 on that edge, with load_ack pulsing in the next cycle.
  - Any older pending value is discarded.
  - clk_out holds its level.
- Channels are fully independent; there is no cross-channel phase alignment.
- Reset mid-operation discards pending loads and returns to RESET_HALF.

Test Plan:
- rst 2 cycles, then en=4'b0001 with no loads -> clk_out[0] rises on the 20th edge after reset release, period 40, rise_tick[0] pulses every 40 cycles, fall_tick 20 cycles after each rise; channels 1-3 stay 0.
- Channel 1: disabled load of half_per=1, then en=1 -> load_ack one cycle after load; clk_out[1] toggles every cycle with alternating rise/fall ticks. Repeat with half_per=0 -> identical waveform.
- Channel 0 running with H=5: load 3 at the 2nd cycle of a high phase -> high phase still 5 cycles; load_ack coincides with the fall; subsequent phases are 3 cycles. Add a second load (7) before the fall -> only 7 is applied, one ack.
- Load asserted exactly on a toggle cycle (H=4, load 2) -> that next phase is 4 cycles, then 2-cycle phases; ack at the second toggle.
- en dropped mid-phase for 10 cycles (H=6, cnt=3) -> clk_out and cnt frozen, no ticks; after re-enable, the toggle occurs 3 cycles later.
- All four channels at H=2,3,5,20 with rst pulsed at cycle 57 -> all outputs 0 the cycle after rst; pending loads lost; restart at H=20 regardless of prior values.
